// File: rtl/aardvark_pkg.sv
// ---------------------------------------------------------------------------
// aardvark_pkg
//
// Shared definitions for the fetch/PC side of the aardvark core:
//   - fetch_state_t : sequencer states IDLE, FETCH, DECODE, EXEC, MEMWAIT
//   - NEXT_*        : encodings of the decoder's nextctrl return
//   - field bounds  : where the opcode, branch/jump immediate and funct bit
//                     live inside an 8-bit instruction
// ---------------------------------------------------------------------------
package aardvark_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXEC    = 3'd3,
        MEMWAIT = 3'd4
    } fetch_state_t;

    localparam logic [1:0] NEXT_NORM = 2'b00;
    localparam logic [1:0] NEXT_MEM  = 2'b01;
    localparam logic [1:0] NEXT_JAL  = 2'b10;

    localparam int OPC_MSB   = 7;
    localparam int OPC_LSB   = 5;
    localparam int IMM_MSB   = 4;
    localparam int IMM_LSB   = 1;
    localparam int FUNCT_BIT = 0;
    localparam int IMM_W     = IMM_MSB - IMM_LSB + 1;

endpackage

// File: rtl/next_pc_calc.sv
// ---------------------------------------------------------------------------
// next_pc_calc
//
// Purely combinational next-PC selection for the fetch sequencer.
//
// Ports:
//   pc_i        current PC
//   imm_i       4-bit immediate from the instruction (branch offset / jump
//               target low nibble)
//   jctrl_i     jump
//   jrctrl_i    jump to return register
//   beqctrl_i   branch-if-equal
//   alu_zero_i  ALU equality result
//   ra_value_i  return-address register contents
//   pc_plus1_o  pc + 1 (also the jal return address)
//   next_pc_o   selected next PC
// ---------------------------------------------------------------------------
module next_pc_calc
    import aardvark_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [IMM_W-1:0]  imm_i,
    input  logic              jctrl_i,
    input  logic              jrctrl_i,
    input  logic              beqctrl_i,
    input  logic              alu_zero_i,
    input  logic [ADDR_W-1:0] ra_value_i,
    output logic [ADDR_W-1:0] pc_plus1_o,
    output logic [ADDR_W-1:0] next_pc_o
);

    logic [ADDR_W-1:0] imm_sext;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] jump_target;

    // All arithmetic wraps naturally at ADDR_W bits.
    assign pc_plus1_o    = pc_i + ADDR_W'(1);
    assign imm_sext      = {{(ADDR_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};
    assign branch_target = pc_plus1_o + imm_sext;
    // Jumps stay inside the current 16-instruction page.
    assign jump_target   = {pc_i[ADDR_W-1:IMM_W], imm_i};

    // beq outranks j, so a not-taken branch falls through to pc+1 even if
    // the decoder also raised jctrl.
    always_comb begin
        next_pc_o = pc_plus1_o;
        if (jrctrl_i) begin
            next_pc_o = ra_value_i;
        end else if (beqctrl_i) begin
            next_pc_o = alu_zero_i ? branch_target : pc_plus1_o;
        end else if (jctrl_i) begin
            next_pc_o = jump_target;
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// ---------------------------------------------------------------------------
// pc_fetch
//
// Program counter and instruction-fetch sequencer sitting in front of the
// control decoder. Fetches one instruction over the imem req/ack handshake,
// hands opcode/funct to the decoder, then uses the decoder's returns to pick
// the next PC. Sequence: FETCH -> DECODE -> EXEC (-> MEMWAIT for data-memory
// ops) -> FETCH, parking in IDLE whenever run is low at an instruction end.
//
// Ports:
//   clk, rst          clock (rising edge) / asynchronous active-high reset
//   run               allow leaving IDLE and continuing to fetch
//   imem_addr         fetch address (always equals pc)
//   imem_req          fetch request, high for the whole FETCH state
//   imem_ack          imem_rdata valid this cycle
//   imem_rdata        fetched instruction
//   inst1, inst2      opcode ir[7:5] and funct ir[0] to the decoder
//   jctrl, jrctrl, beqctrl, jalctrl, nextctrl  decoder returns
//   alu_zero          ALU equality result for beq
//   ra_value          return-address register contents for jr
//   ra_wdata, ra_we   jal return address (pc+1) and one-cycle write strobe
//   pc                current PC
//   halted            self-loop detected (only with PC_HALT_DETECT_EN)
//
// Build option:
//   PC_HALT_DETECT_EN  when defined, a jump/branch whose target equals its
//                      own address sets halted and parks the sequencer in
//                      IDLE until reset. Otherwise halted is tied low and a
//                      self-loop keeps refetching.
// ---------------------------------------------------------------------------
module pc_fetch
    import aardvark_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                INST_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [2:0]        inst1,
    output logic              inst2,
    input  logic              jctrl,
    input  logic              jrctrl,
    input  logic              beqctrl,
    input  logic              jalctrl,
    input  logic [1:0]        nextctrl,
    input  logic              alu_zero,
    input  logic [ADDR_W-1:0] ra_value,
    output logic [ADDR_W-1:0] ra_wdata,
    output logic              ra_we,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] ir_q, ir_d;
    logic              ra_we_q, ra_we_d;
    logic [ADDR_W-1:0] ra_wdata_q, ra_wdata_d;

    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] pc_plus1;
    logic              halt_hit;
    logic              halt_lock;

    next_pc_calc #(
        .ADDR_W (ADDR_W)
    ) u_next_pc_calc (
        .pc_i       (pc_q),
        .imm_i      (ir_q[IMM_MSB:IMM_LSB]),
        .jctrl_i    (jctrl),
        .jrctrl_i   (jrctrl),
        .beqctrl_i  (beqctrl),
        .alu_zero_i (alu_zero),
        .ra_value_i (ra_value),
        .pc_plus1_o (pc_plus1),
        .next_pc_o  (next_pc)
    );

`ifdef PC_HALT_DETECT_EN
    logic halted_q;

    // A control transfer that lands on itself can never make progress.
    assign halt_hit  = (jctrl | jrctrl | beqctrl | jalctrl) && (next_pc == pc_q);
    assign halt_lock = halted_q;
    assign halted    = halted_q;

    // Sticky until reset; it also blocks IDLE from restarting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else if (state_q == EXEC && halt_hit) begin
            halted_q <= 1'b1;
        end
    end
`else
    logic unused_jalctrl;

    // jalctrl only feeds halt detection; the jal write-back is keyed off
    // nextctrl.
    assign unused_jalctrl = jalctrl;
    assign halt_hit       = 1'b0;
    assign halt_lock      = 1'b0;
    assign halted         = 1'b0;
`endif

    // Sequencer next state. The decoder output is combinational from ir, so
    // DECODE is a single settling cycle and EXEC commits the new PC.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ra_we_d    = 1'b0;
        ra_wdata_d = ra_wdata_q;
        case (state_q)
            IDLE: begin
                if (run && !halt_lock) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = EXEC;
            end
            EXEC: begin
                pc_d = next_pc;
                if (nextctrl == NEXT_JAL) begin
                    ra_we_d    = 1'b1;
                    ra_wdata_d = pc_plus1;
                end
                if (halt_hit) begin
                    state_d = IDLE;
                end else begin
                    case (nextctrl)
                        NEXT_MEM:            state_d = MEMWAIT;
                        NEXT_NORM, NEXT_JAL: state_d = run ? FETCH : IDLE;
                        default:             state_d = run ? FETCH : IDLE;
                    endcase
                end
            end
            MEMWAIT: begin
                state_d = run ? FETCH : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops imem_req at once because the
    // request is decoded straight from the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ra_we_q    <= 1'b0;
            ra_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ra_we_q    <= ra_we_d;
            ra_wdata_q <= ra_wdata_d;
        end
    end

    assign imem_req  = (state_q == FETCH);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign inst1     = ir_q[OPC_MSB:OPC_LSB];
    assign inst2     = ir_q[FUNCT_BIT];
    assign ra_we     = ra_we_q;
    assign ra_wdata  = ra_wdata_q;

endmodule

// File: tb/tb_pc_fetch.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch
//
// Directed bench for pc_fetch. The instruction memory answers every request
// in the same cycle with whatever instruction the current vector supplies;
// the vector also plays the decoder's returns. Each vector queues the fetch
// address (and fetch-to-fetch spacing) it should lead to, the opcode/funct
// it should present and any jal write-back; a monitor on the falling edge
// pops and compares as the DUT produces them.
// Honours PC_HALT_DETECT_EN to match the DUT build.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pc_fetch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [7:0] imem_addr;
    logic       imem_req;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic [2:0] inst1;
    logic       inst2;
    logic       jctrl    = 1'b0;
    logic       jrctrl   = 1'b0;
    logic       beqctrl  = 1'b0;
    logic       jalctrl  = 1'b0;
    logic [1:0] nextctrl = 2'b00;
    logic       alu_zero = 1'b0;
    logic [7:0] ra_value = 8'h00;
    logic [7:0] ra_wdata;
    logic       ra_we;
    logic [7:0] pc;
    logic       halted;

    logic       memOn    = 1'b1;
    logic       forceAck = 1'b0;
    logic [7:0] instReg  = 8'h00;
    logic       monOn    = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [7:0] addr;
        int         gap;
    } fetchExp_t;

    fetchExp_t  fetchQ[$];
    logic [3:0] instQ[$];
    logic [7:0] raQ[$];

    assign imem_ack   = (imem_req & memOn) | forceAck;
    assign imem_rdata = instReg;

    pc_fetch #(
        .ADDR_W   (8),
        .INST_W   (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst1      (inst1),
        .inst2      (inst2),
        .jctrl      (jctrl),
        .jrctrl     (jrctrl),
        .beqctrl    (beqctrl),
        .jalctrl    (jalctrl),
        .nextctrl   (nextctrl),
        .alu_zero   (alu_zero),
        .ra_value   (ra_value),
        .ra_wdata   (ra_wdata),
        .ra_we      (ra_we),
        .pc         (pc),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Single comparison point shared by the monitor and the directed checks.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    // Wait for the next fetch, answer it with one instruction plus decoder
    // returns, and queue what that instruction should produce.
    task automatic applyStimulus(input logic [7:0] inst, input logic [3:0] expInst,
                                 input logic j, input logic jr, input logic beq,
                                 input logic jal, input logic [1:0] nxt,
                                 input logic zero, input logic [7:0] ra,
                                 input logic pushNext, input logic [7:0] expNext,
                                 input int expGap, input logic expJal,
                                 input logic [7:0] expRa);
        int waitCycles;
        waitCycles = 0;
        @(negedge clk);
        while (!imem_req && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!imem_req) begin
            checkOutput("fetch_timeout", 32'd0, 32'd1);
        end else begin
            instReg  = inst;
            jctrl    = j;
            jrctrl   = jr;
            beqctrl  = beq;
            jalctrl  = jal;
            nextctrl = nxt;
            alu_zero = zero;
            ra_value = ra;
            instQ.push_back(expInst);
            if (pushNext) fetchQ.push_back('{expNext, expGap});
            if (expJal) raQ.push_back(expRa);
            @(posedge clk);
        end
    endtask

    // Monitor: fetch starts, decode entries and jal strobes are the DUT's
    // observable events.
    int   cycleCount = 0;
    int   lastFetch  = 0;
    logic prevReq    = 1'b0;

    always @(negedge clk) begin
        if (monOn) begin
            if (imem_req && !prevReq) begin
                if (fetchQ.size() == 0) begin
                    checkOutput("fetch_unexpected", 32'(imem_addr), 32'h100);
                end else begin
                    fetchExp_t e;
                    e = fetchQ.pop_front();
                    checkOutput("fetch_addr", 32'(imem_addr), 32'(e.addr));
                    if (e.gap != 0) checkOutput("fetch_gap", 32'(cycleCount - lastFetch), 32'(e.gap));
                end
                lastFetch <= cycleCount;
            end
            if (!imem_req && prevReq) begin
                if (instQ.size() == 0) begin
                    checkOutput("decode_unexpected", 32'({inst1, inst2}), 32'h100);
                end else begin
                    logic [3:0] ei;
                    ei = instQ.pop_front();
                    checkOutput("inst1_inst2", 32'({inst1, inst2}), 32'(ei));
                end
            end
            if (ra_we) begin
                if (raQ.size() == 0) begin
                    checkOutput("ra_we_unexpected", 32'(ra_wdata), 32'h100);
                end else begin
                    logic [7:0] er;
                    er = raQ.pop_front();
                    checkOutput("ra_wdata", 32'(ra_wdata), 32'(er));
                end
            end
        end
        prevReq    <= imem_req;
        cycleCount <= cycleCount + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run did not finish, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state.
        @(negedge clk);
        checkOutput("rst_pc", 32'(pc), 32'h00);
        checkOutput("rst_imem_addr", 32'(imem_addr), 32'h00);
        checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
        checkOutput("rst_ra_we", 32'(ra_we), 32'd0);
        checkOutput("rst_ra_wdata", 32'(ra_wdata), 32'h00);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_inst", 32'({inst1, inst2}), 32'd0);

        fetchQ.push_back('{8'h00, 0});
        monOn = 1'b1;
        rst   = 1'b0;
        run   = 1'b1;

        //            inst   opc+f    j     jr    beq   jal   nxt    zero  ra     push  next   gap  jal?  ra_exp
        applyStimulus(8'h01, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b1, 8'h01, 3, 1'b0, 8'h00);
        applyStimulus(8'h01, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b1, 8'h02, 3, 1'b0, 8'h00);
        applyStimulus(8'h60, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h10, 1'b1, 8'h10, 3, 1'b0, 8'h00);
        applyStimulus(8'h9C, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 8'h00, 1'b1, 8'h0F, 3, 1'b0, 8'h00);
        applyStimulus(8'h60, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h10, 1'b1, 8'h10, 3, 1'b0, 8'h00);
        applyStimulus(8'h9C, 4'b1000, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 1'b1, 8'h11, 3, 1'b0, 8'h00);
        applyStimulus(8'h60, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h23, 1'b1, 8'h23, 3, 1'b0, 8'h00);
        applyStimulus(8'hCA, 4'b1100, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 8'h00, 1'b1, 8'h25, 3, 1'b1, 8'h24);
        applyStimulus(8'h40, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 8'h00, 1'b1, 8'h26, 4, 1'b0, 8'h00);
        applyStimulus(8'h60, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h80, 1'b1, 8'h80, 3, 1'b0, 8'h00);
        applyStimulus(8'hBE, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b1, 8'h8F, 3, 1'b0, 8'h00);
        applyStimulus(8'h8E, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 8'h00, 1'b1, 8'h97, 3, 1'b0, 8'h00);
        applyStimulus(8'h60, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'hFF, 1'b1, 8'hFF, 3, 1'b0, 8'h00);
        applyStimulus(8'h01, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b1, 8'h00, 3, 1'b0, 8'h00);
        applyStimulus(8'h90, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 8'h00, 1'b1, 8'hF9, 3, 1'b0, 8'h00);
        applyStimulus(8'h60, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h04, 1'b1, 8'h04, 3, 1'b0, 8'h00);

`ifdef PC_HALT_DETECT_EN
        // Jump-to-self at 0x04 halts; nothing further may be fetched.
        applyStimulus(8'hA8, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 8'h00, 0, 1'b0, 8'h00);
        repeat (12) @(negedge clk);
        checkOutput("halt_flag", 32'(halted), 32'd1);
        checkOutput("halt_pc", 32'(pc), 32'h04);
        checkOutput("halt_req", 32'(imem_req), 32'd0);
`else
        // Jump-to-self just refetches the same address.
        applyStimulus(8'hA8, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b1, 8'h04, 3, 1'b0, 8'h00);
        applyStimulus(8'h01, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b1, 8'h05, 3, 1'b0, 8'h00);
        // Drop run mid-instruction: it completes, then the sequencer idles.
        applyStimulus(8'h01, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 8'h00, 0, 1'b0, 8'h00);
        #1 run = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("idle_pc", 32'(pc), 32'h06);
        checkOutput("idle_req", 32'(imem_req), 32'd0);
        checkOutput("no_halt", 32'(halted), 32'd0);
        fetchQ.push_back('{8'h06, 0});
        run = 1'b1;
        applyStimulus(8'h01, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 8'h00, 0, 1'b0, 8'h00);
        #1 run = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("idle_pc2", 32'(pc), 32'h07);
`endif

        checkOutput("fetchQ_drained", 32'(fetchQ.size()), 32'd0);
        checkOutput("instQ_drained", 32'(instQ.size()), 32'd0);
        checkOutput("raQ_drained", 32'(raQ.size()), 32'd0);
        monOn = 1'b0;

        // Reset in the middle of a stalled fetch, then a late ack.
        memOn = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("fetch_held", 32'(imem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_async_req", 32'(imem_req), 32'd0);
        checkOutput("rst_async_pc", 32'(pc), 32'h00);
        checkOutput("rst_async_inst", 32'({inst1, inst2}), 32'd0);
        checkOutput("rst_async_halted", 32'(halted), 32'd0);
        run      = 1'b0;
        instReg  = 8'hFF;
        forceAck = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("late_ack_inst", 32'({inst1, inst2}), 32'd0);
        checkOutput("late_ack_pc", 32'(pc), 32'h00);
        checkOutput("late_ack_req", 32'(imem_req), 32'd0);
        checkOutput("late_ack_ra_we", 32'(ra_we), 32'd0);
        forceAck = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
